// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and constants for the UART RX frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversample edge counter and bit counter; both clear whenever disabled.
module uart_rx_edge_bit_cnt #(
    parameter int PRE_W  = 6,
    parameter int BCNT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [PRE_W-1:0]  prescale_i,
    output logic [PRE_W-1:0]  edge_cnt_o,
    output logic [BCNT_W-1:0] bit_cnt_o,
    output logic              wrap_o
);

    logic [PRE_W-1:0]  edge_q, edge_d;
    logic [BCNT_W-1:0] bit_q, bit_d;

    assign wrap_o     = en_i && (edge_q == prescale_i - 1'b1);
    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;

    always_comb begin
        edge_d = (!en_i || wrap_o) ? '0 : edge_q + 1'b1;
        bit_d  = !en_i ? '0 : bit_q + BCNT_W'(wrap_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX frame FSM, config latch, deserialiser and parity/stop checks.
// UART_RX_BREAK_DET_EN adds brk_det and holds off new frames until the line returns high.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PRE_W  = 6,
    parameter int BCNT_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [PRE_W-1:0]  Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    output logic [PRE_W-1:0]  edge_cnt,
    output logic [BCNT_W-1:0] bit_cnt,
    output logic              dat_samp_en,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic              brk_det
`endif
);

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              pen_q, pen_d, ptyp_q, ptyp_d, bad_q, bad_d;
    logic [DATA_W-1:0] shift_q, shift_d, pdata_q, pdata_d;
    logic              dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
    logic              end_bit, start_frame;
`ifdef UART_RX_BREAK_DET_EN
    logic              brk_q, brk_d, wait_q, wait_d, pbit_q, pbit_d;
    assign start_frame = (state_q == IDLE || state_q == DONE) && !RX_IN && !wait_q;
    assign brk_det     = brk_q;
`else
    assign start_frame = (state_q == IDLE || state_q == DONE) && !RX_IN;
`endif

    assign dat_samp_en = state_q inside {START, DATA, PARITY, STOP};
    assign P_DATA      = pdata_q;
    assign data_valid  = dv_q;
    assign par_err     = perr_q;
    assign stp_err     = serr_q;

    uart_rx_edge_bit_cnt #(.PRE_W(PRE_W), .BCNT_W(BCNT_W)) u_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .en_i       (dat_samp_en),
        .prescale_i (pre_q),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .wrap_o     (end_bit)
    );

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        bad_d   = bad_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        dv_d    = 1'b0;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_d   = 1'b0;
        wait_d  = wait_q && !RX_IN;
        pbit_d  = pbit_q;
`endif
        if (start_frame) begin
            pre_d  = Prescale;
            pen_d  = PAR_EN;
            ptyp_d = PAR_TYP;
            bad_d  = 1'b0;
        end
        case (state_q)
            IDLE:  state_d = start_frame ? START : IDLE;
            START: if (end_bit) state_d = sampled_bit ? IDLE : DATA;
            DATA: if (end_bit) begin
                shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
                if (bit_cnt == BCNT_W'(DATA_W)) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (end_bit) begin
                perr_d  = sampled_bit != (^shift_q ^ (ptyp_q == PAR_ODD));
                bad_d   = perr_d;
                state_d = STOP;
`ifdef UART_RX_BREAK_DET_EN
                pbit_d  = sampled_bit;
`endif
            end
            STOP: if (end_bit) begin
                state_d = DONE;
                serr_d  = !sampled_bit;
                dv_d    = sampled_bit && !bad_q;
                pdata_d = dv_d ? shift_q : pdata_q;
`ifdef UART_RX_BREAK_DET_EN
                // an all-zero frame is a line break, not a framing error
                if (!sampled_bit && shift_q == '0 && !(pen_q && pbit_q)) begin
                    brk_d  = 1'b1;
                    serr_d = 1'b0;
                    wait_d = 1'b1;
                end
`endif
            end
            DONE:    state_d = start_frame ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pre_q   <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            bad_q   <= 1'b0;
            shift_q <= '0;
            pdata_q <= '0;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q   <= 1'b0;
            wait_q  <= 1'b0;
            pbit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            bad_q   <= bad_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q   <= brk_d;
            wait_q  <= wait_d;
            pbit_q  <= pbit_d;
`endif
        end
    end

endmodule
